// File: rtl/bru_pkg.sv
// Shared encodings and result type for the branch resolution stage.
package bru_pkg;

    localparam int BRU_XLEN = 32;

    // in_op encodings
    localparam logic [1:0] BRU_OP_BR   = 2'b00;
    localparam logic [1:0] BRU_OP_JAL  = 2'b01;
    localparam logic [1:0] BRU_OP_JALR = 2'b10;
    localparam logic [1:0] BRU_OP_RSV  = 2'b11;

    // Conditional branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Resolved result as seen by the fetch redirect logic (RV32 width)
    typedef struct packed {
        logic                taken;
        logic [BRU_XLEN-1:0] target;
        logic [BRU_XLEN-1:0] link;
        logic                mispredict;
        logic                illegal;
    } bru_res_t;

endpackage

// File: rtl/bru_cmp.sv
// Combinational branch-condition comparator: funct3 selects the relation,
// undefined funct3 values flag illegal and force the condition low.
module bru_cmp
    import bru_pkg::*;
#(
    parameter int XLEN = BRU_XLEN
) (
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            cond,
    output logic            illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    // Select the relation for this funct3; 010/011 are not branches
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (fun3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = !lt_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = !lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates branch/JAL/JALR, computes target and
// link, checks the front-end prediction and registers one result per
// instruction behind a valid/ready output register.
// Optional build macro BRU_STATS_EN adds saturating handoff counters
// (stat_branches, stat_mispredicts).
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN = BRU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [2:0]      in_fun3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_link,
    output logic            out_mispredict,
    output logic            out_illegal
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    // Same layout as bru_res_t, but sized by this instance's XLEN
    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
        logic            mispredict;
        logic            illegal;
    } res_t;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic            cmp_cond;
    logic            cmp_illegal;
    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] rs1_imm;
    logic [XLEN-1:0] pc_plus4;
    res_t            res_new;

    res_t            res_d,   res_q;
    logic            valid_d, valid_q;
    logic            accept;
    logic            handoff;

    bru_cmp #(.XLEN(XLEN)) u_cmp (
        .fun3    (in_fun3),
        .a       (in_rs1),
        .b       (in_rs2),
        .cond    (cmp_cond),
        .illegal (cmp_illegal)
    );

    assign is_br    = (in_op == BRU_OP_BR);
    assign is_jal   = (in_op == BRU_OP_JAL);
    assign is_jalr  = (in_op == BRU_OP_JALR);

    // All sums wrap modulo 2^XLEN
    assign pc_imm   = in_pc + in_imm;
    assign rs1_imm  = in_rs1 + in_imm;
    assign pc_plus4 = in_pc + FOUR;

    // Resolve direction, next PC and prediction check for the incoming op
    always_comb begin
        res_new            = '0;
        res_new.illegal    = (in_op == BRU_OP_RSV) || (is_br && cmp_illegal);
        res_new.taken      = !res_new.illegal &&
                             (is_jal || is_jalr || (is_br && cmp_cond));
        res_new.link       = pc_plus4;
        if (!res_new.taken)
            res_new.target = pc_plus4;
        else if (is_jalr)
            res_new.target = {rs1_imm[XLEN-1:1], 1'b0};
        else
            res_new.target = pc_imm;
        res_new.mispredict = !res_new.illegal &&
                             ((res_new.taken != in_pred_taken) ||
                              (res_new.taken && in_pred_taken &&
                               (res_new.target != in_pred_target)));
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = valid_q && out_ready;

    // Output register control: flush overrides both handoff and accept
    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        if (handoff)
            valid_d = 1'b0;
        if (accept && !flush) begin
            valid_d = 1'b1;
            res_d   = res_new;
        end
        if (flush)
            valid_d = 1'b0;
    end

    // Output register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = res_q.taken;
    assign out_target     = res_q.target;
    assign out_link       = res_q.link;
    assign out_mispredict = res_q.mispredict;
    assign out_illegal    = res_q.illegal;

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_d,  stat_br_q;
    logic [31:0] stat_mis_d, stat_mis_q;

    // Count legal results at handoff; both counters stick at all-ones
    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (handoff && !res_q.illegal) begin
            if (stat_br_q != '1)
                stat_br_d = stat_br_q + 32'd1;
            if (res_q.mispredict && (stat_mis_q != '1))
                stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    // Counter state; flush does not clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (XLEN=32).
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_fun3;
    logic [31:0] in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
    logic        in_pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target, out_link;
    logic        out_mispredict, out_illegal;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int errs = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_fun3        (in_fun3),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_link       (out_link),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptg);
        in_op = op; in_fun3 = f3; in_rs1 = a; in_rs2 = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptg;
    endtask

    // One instruction accepted at the next edge; returns #1 after that edge
    task automatic send(input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg);
        @(negedge clk);
        drive(op, f3, a, b, pc, imm, pt, ptg);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic tk, input logic [31:0] tgt,
                           input logic [31:0] lnk, input logic mis, input logic ill);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".taken"}, {31'd0, out_taken}, {31'd0, tk});
        chk({tag, ".target"}, out_target, tgt);
        chk({tag, ".link"}, out_link, lnk);
        chk({tag, ".mis"}, {31'd0, out_mispredict}, {31'd0, mis});
        chk({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(2'b00, 3'b000, 0, 0, 0, 0, 1'b0, 0);
        #12;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.taken", {31'd0, out_taken}, 32'd0);
        chk("rst.target", out_target, 32'd0);
        chk("rst.link", out_link, 32'd0);
        chk("rst.mis", {31'd0, out_mispredict}, 32'd0);
        chk("rst.ill", {31'd0, out_illegal}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Conditional branches
        send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
        chk_res("beq", 1'b1, 32'h120, 32'h104, 1'b1, 1'b0);
        send(2'b00, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240);
        chk_res("blt", 1'b1, 32'h240, 32'h204, 1'b0, 1'b0);
        send(2'b00, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240);
        chk_res("bltu", 1'b0, 32'h204, 32'h204, 1'b1, 1'b0);
        send(2'b00, 3'b001, 32'd7, 32'd7, 32'h300, 32'h10, 1'b0, 32'h0);
        chk_res("bne", 1'b0, 32'h304, 32'h304, 1'b0, 1'b0);
        send(2'b00, 3'b101, 32'h80000000, 32'd0, 32'h300, 32'h10, 1'b0, 32'h0);
        chk_res("bge", 1'b0, 32'h304, 32'h304, 1'b0, 1'b0);
        send(2'b00, 3'b111, 32'h80000000, 32'd0, 32'h300, 32'hFFFFFFF0, 1'b1, 32'h2F4);
        chk_res("bgeu", 1'b1, 32'h2F0, 32'h304, 1'b1, 1'b0);

        // Jumps
        send(2'b10, 3'b011, 32'h1001, 32'd0, 32'h500, 32'h10, 1'b1, 32'h1010);
        chk_res("jalr", 1'b1, 32'h1010, 32'h504, 1'b0, 1'b0);
        send(2'b10, 3'b000, 32'h1001, 32'd0, 32'h500, 32'h10, 1'b1, 32'h1014);
        chk_res("jalr.tgt", 1'b1, 32'h1010, 32'h504, 1'b1, 1'b0);
        send(2'b01, 3'b010, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10);
        chk_res("jal.wrap", 1'b1, 32'h10, 32'hFFFFFFF4, 1'b0, 1'b0);

        // Illegal encodings and pc+4 wrap
        send(2'b00, 3'b010, 32'd1, 32'd1, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h4);
        chk_res("f3_010", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        send(2'b11, 3'b000, 32'd1, 32'd1, 32'h600, 32'h8, 1'b0, 32'h0);
        chk_res("op_11", 1'b0, 32'h604, 32'h604, 1'b0, 1'b1);

        // Back-to-back with a 2-cycle stall on the first result
        @(negedge clk);
        drive(2'b00, 3'b000, 1, 1, 32'h1000, 32'h100, 1'b1, 32'h1100);
        in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 1, 1, 32'h1010, 32'h100, 1'b1, 32'h1110);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall.valid", {31'd0, out_valid}, 32'd1);
            chk("stall.target", out_target, 32'h1100);
            chk("stall.link", out_link, 32'h1004);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk("b2b.valid", {31'd0, out_valid}, 32'd1);
            chk("b2b.target", out_target, 32'h1100 + 32'h10 * i);
            if (i < 3)
                drive(2'b00, 3'b000, 1, 1, 32'h1000 + 32'h10 * (i + 1), 32'h100,
                      1'b1, 32'h1100 + 32'h10 * (i + 1));
            else
                in_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("b2b.drain", {31'd0, out_valid}, 32'd0);

        // Flush kills held result and simultaneous incoming instruction
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'b01, 3'b000, 0, 0, 32'h700, 32'h40, 1'b1, 32'h740);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("fl.pre", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        chk("fl.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("fl.stay", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset during a stall
        send(2'b01, 3'b000, 0, 0, 32'h800, 32'h40, 1'b0, 32'h0);
        out_ready = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.target", out_target, 32'd0);
        chk("arst.link", out_link, 32'd0);
        chk("arst.taken", {31'd0, out_taken}, 32'd0);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;

`ifdef BRU_STATS_EN
        chk("st.rst_br", stat_branches, 32'd0);
        send(2'b00, 3'b000, 3, 3, 32'h100, 32'h8, 1'b1, 32'h108);
        send(2'b00, 3'b001, 3, 3, 32'h100, 32'h8, 1'b1, 32'h108);
        send(2'b00, 3'b011, 3, 3, 32'h100, 32'h8, 1'b0, 32'h0);
        send(2'b01, 3'b000, 0, 0, 32'h100, 32'h8, 1'b1, 32'h108);
        @(posedge clk); #1;
        chk("st.branches", stat_branches, 32'd3);
        chk("st.mispred", stat_mispredicts, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch resolution stage for the RV32I core. Takes decoded branch/jump operands, evaluates all six conditional branch conditions plus JAL/JALR, computes target and link addresses, and checks the front-end prediction. Outputs one redirect/flush request per resolved instruction through a valid/ready output register. Sits between the execute operand mux and the fetch redirect logic.

## Interface
- XLEN, 32, operand/address width (≥32, even)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input instruction valid
- in_ready  out  1  stage can accept
- in_op  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved (treated as illegal)
- in_fun3  in  3  branch funct3 (used only when in_op=00)
- in_rs1, in_rs2  in  XLEN  operands
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- in_pred_taken  in  1  front-end predicted taken
- in_pred_target  in  XLEN  front-end predicted target
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_taken  out  1  resolved taken
- out_target  out  XLEN  resolved next PC (target if taken, else pc+4)
- out_link  out  XLEN  pc+4 (rd write value for JAL/JALR)
- out_mispredict  out  1  redirect required
- out_illegal  out  1  undefined fun3/op; taken=0, mispredict=0

## Operation
- Conditions: 000 beq A==B; 001 bne A!=B; 100 blt signed A<B; 101 bge signed A>=B; 110 bltu unsigned; 111 bgeu unsigned. 010/011 → out_illegal=1, not taken. Every output fully defined every cycle; no latches.
- Targets: branch/JAL = pc+imm; JALR = (rs1+imm) with bit0 cleared. All sums modulo 2^XLEN (wrap silently). out_link = pc+4 modulo 2^XLEN.
- JAL/JALR always taken; fun3 ignored.
- Mispredict = taken != pred_taken, or (taken && pred_taken && target != pred_target). Illegal never mispredicts.
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
- Output register holds all out_* stable while out_valid && !out_ready.
- flush: next cycle out_valid=0; incoming instruction in same cycle discarded; flush wins over simultaneous accept.

## Timing
- Latency 1 cycle: accepted at edge N → out_valid at N+1 (after edge N).
- Throughput 1/cycle with out_ready held high.
- Reset (async, any time, including mid-transfer): out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_target=0, out_link=0; in_ready=1 once rst_n high.
- out_* data registers update only on accept; out_valid changes on accept, handoff, flush or reset.

## Configuration
- BRU_STATS_EN defined: adds outputs stat_branches and stat_mispredicts (32 bits each), incremented on each output handoff (out_valid && out_ready) for non-illegal results, mispredict counter only when out_mispredict=1; saturate at 2^32-1; cleared by reset, not by flush.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package bru_pkg: op encodings (BRU_OP_BR/JAL/JALR), fun3 constants (F3_BEQ…F3_BGEU), result struct typedef {taken, target, link, mispredict, illegal}.
- Sub-module bru_cmp: purely combinational XLEN comparator (fun3 → cond, illegal), instantiated once; top holds the adder, prediction check and output register.

## Test plan
- beq rs1=5 rs2=5 pc=0x100 imm=0x20 pred_taken=0 → next cycle taken=1, target=0x120, mispredict=1.
- blt rs1=0xFFFFFFFF rs2=1 → taken=1; bltu same operands → taken=0, target=pc+4.
- JALR rs1=0x1001 imm=0x10 pred_taken=1 pred_target=0x1010 → target=0x1010, link=pc+4, mispredict=0; pred_target=0x1014 → mispredict=1.
- fun3=010 → illegal=1, taken=0, mispredict=0; pc=0xFFFFFFFC → link=0x0 (wrap).
- Back-to-back 4 branches with out_ready low 2 cycles → outputs held stable, in_ready=0, no loss or duplication; flush with in_valid=1 → out_valid=0 next cycle.
- rst_n low mid-stall → out_valid=0 immediately; with BRU_STATS_EN, 3 branches (1 mispredict) → stat_branches=3, stat_mispredicts=1.
